// File: rtl/mips_pkg.sv
// Shared definitions for the instruction-fetch path: instruction width,
// the error-response NOP, and the responder state encoding.
package mips_pkg;

    localparam int INSTR_W = 32;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE,
        RESP,
        STALL
    } imem_state_t;

    // Unsigned 32-bit word offset from the base; addresses below the base wrap to a huge index.
    function automatic logic [31:0] word_index(input logic [31:0] pc, input logic [31:0] base);
        return (pc - base) >> 2;
    endfunction

endpackage

// File: rtl/imem_responder_if.sv
// Fetch request/response handshake between the core (master) and the
// instruction-memory responder (slave).
interface imem_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_pc;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_instr;
    logic        rsp_err;

    modport master (
        output req_valid, req_pc, rsp_ready,
        input  req_ready, rsp_valid, rsp_instr, rsp_err
    );

    modport slave (
        input  req_valid, req_pc, rsp_ready,
        output req_ready, rsp_valid, rsp_instr, rsp_err
    );

endinterface

// File: rtl/imem_responder_ram.sv
// Single-port DEPTH x 32 word RAM with a registered read port: data appears
// one cycle after the address is presented with re high.
module imem_ram #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    // NOTE: the array and its read register have no reset so they map onto
    // block RAM; a reset port would force the array into flops.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: accepts PC fetch requests, checks alignment
// and range, and returns the RAM word (or a NOP with rsp_err) one cycle later.
module imem_responder
    import mips_pkg::*;
#(
    parameter int          DEPTH     = 256,
    parameter int          AW        = $clog2(DEPTH),
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    imem_responder_if.slave   bus,
    input  logic              load_en,
    input  logic [AW-1:0]     load_addr,
    input  logic [31:0]       load_data,
    output logic [31:0]       fetch_cnt
);

    imem_state_t        state;
    imem_state_t        state_nxt;
    logic               req_ready_int;
    logic               rsp_valid_int;
    logic               accept;
    logic               handshake;
    logic               pc_bad;
    logic               err_q;
    logic [31:0]        idx_full;
    logic [AW-1:0]      ram_addr;
    logic [INSTR_W-1:0] ram_q;

    // Address decode happens in the accept cycle; only the error flag is kept.
    assign idx_full  = word_index(bus.req_pc, BASE_ADDR);
    assign pc_bad    = (bus.req_pc[1:0] != 2'b00) || (idx_full >= 32'(DEPTH));
    assign accept    = bus.req_valid && req_ready_int;
    assign handshake = rsp_valid_int && bus.rsp_ready;
    assign ram_addr  = load_en ? load_addr : idx_full[AW-1:0];

    imem_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (load_en),
        .re    (accept && !pc_bad),
        .addr  (ram_addr),
        .wdata (load_data),
        .rdata (ram_q)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: state_nxt is defaulted before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) state_nxt = RESP;
            end
            RESP: begin
                if (!bus.rsp_ready) state_nxt = STALL;
                else if (accept)    state_nxt = RESP;
                else                state_nxt = IDLE;
            end
            STALL: begin
                if (bus.rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A stalled slot frees only after its handshake, so STALL never accepts.
    always_comb begin
        rsp_valid_int = !rst && (state != IDLE);
        req_ready_int = 1'b0;
        if (!rst && !load_en) begin
            case (state)
                IDLE:    req_ready_int = 1'b1;
                RESP:    req_ready_int = bus.rsp_ready;
                default: req_ready_int = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= pc_bad;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt <= '0;
        end else if (handshake) begin
            fetch_cnt <= fetch_cnt + 32'd1;
        end
    end

    assign bus.req_ready = req_ready_int;
    assign bus.rsp_valid = rsp_valid_int;
    assign bus.rsp_err   = rsp_valid_int && err_q;
    assign bus.rsp_instr = (rsp_valid_int && !err_q) ? ram_q : NOP_INSTR;

endmodule
